// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding fetch/load/store sequencer onto a word-addressed RAM port.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word/fetch accesses instead of issuing them.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic        mem_req,
   input  logic        addr_src,
   input  logic [31:0] pc,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   output logic        ram_req,
   output logic [29:0] ram_addr,
   output logic        ram_we,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_wdata,
   input  logic        ram_ack,
   input  logic [31:0] ram_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        busy,
   output logic        fault
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state, state_nx;
   logic accept, misalign, fault_q, fetch_q, signed_q;
   logic [1:0] size_q, lane_q, req_size;
   logic [31:0] req_addr, req_wdata, load_ext;
   logic [3:0] req_be;
   logic [15:0] half_v;
   logic [7:0] byte_v;
   // A fetch is treated as a word access so alignment and lane logic are shared.
   assign req_addr = (mem_req && addr_src) ? alu_result : pc;
   assign req_size = mem_req ? mem_size : 2'b10;
   assign req_be = req_size[1] ? 4'hF : req_size[0] ? (req_addr[1] ? 4'hC : 4'h3) : 4'b0001 << req_addr[1:0];
   assign req_wdata = !mem_req ? 32'h0 : req_size[1] ? store_data :
                      req_size[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = req_size[1] ? |req_addr[1:0] : req_size[0] & req_addr[0];
   assign fault = (state == DONE) && fault_q;
`else
   assign misalign = 1'b0;
   assign fault = 1'b0;
`endif
   always_comb begin
      accept = 1'b0;
      state_nx = state;
      accept = (state == IDLE) && (fetch_req || mem_req);
      state_nx = (state == IDLE) ? (accept ? (misalign ? DONE : REQ) : IDLE) :
                 (state == REQ) ? (ram_ack ? DONE : REQ) : IDLE;
   end
   assign byte_v = lane_q[1] ? (lane_q[0] ? ram_rdata[31:24] : ram_rdata[23:16]) :
                               (lane_q[0] ? ram_rdata[15:8] : ram_rdata[7:0]);
   assign half_v = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
   assign load_ext = size_q[1] ? ram_rdata :
                     size_q[0] ? {{16{signed_q & half_v[15]}}, half_v} : {{24{signed_q & byte_v[7]}}, byte_v};
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ram_addr <= '0;
         ram_we <= 1'b0;
         ram_be <= '0;
         ram_wdata <= '0;
         fetch_q <= 1'b0;
         signed_q <= 1'b0;
         size_q <= '0;
         lane_q <= '0;
         fault_q <= 1'b0;
         instr <= '0;
         load_data <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ram_addr <= req_addr[31:2];
            ram_we <= mem_req && mem_we;
            ram_be <= req_be;
            ram_wdata <= req_wdata;
            fetch_q <= !mem_req;
            signed_q <= mem_signed;
            size_q <= req_size;
            lane_q <= req_addr[1:0];
            fault_q <= misalign;
         end
         if (state == REQ && ram_ack && fetch_q)
            instr <= ram_rdata;
         if (state == REQ && ram_ack && !fetch_q && !ram_we)
            load_data <= load_ext;
      end
   end
   assign ram_req = (state == REQ);
   assign busy = (state != IDLE);
   assign instr_valid = (state == DONE) && fetch_q && !fault_q;
   assign load_valid = (state == DONE) && !fetch_q && !ram_we && !fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed transactions checked against a transaction-level model.
module tb_mem_access_unit;
   logic clk = 1'b0, reset = 1'b1;
   logic fetch_req = 0, mem_req = 0, addr_src = 0, mem_we = 0, mem_signed = 0, ram_ack = 0;
   logic [31:0] pc = 0, alu_result = 0, store_data = 0, ram_rdata = 0;
   logic [1:0] mem_size = 0;
   logic ram_req, ram_we, instr_valid, load_valid, busy, fault;
   logic [29:0] ram_addr;
   logic [3:0] ram_be;
   logic [31:0] ram_wdata, instr, load_data;
   logic [31:0] exp_instr = 0, exp_load = 0;
   int n_checks = 0, n_fail = 0;

   mem_access_unit dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .mem_req(mem_req), .addr_src(addr_src),
      .pc(pc), .alu_result(alu_result), .store_data(store_data), .mem_we(mem_we),
      .mem_size(mem_size), .mem_signed(mem_signed), .ram_req(ram_req), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_ack(ram_ack),
      .ram_rdata(ram_rdata), .instr(instr), .instr_valid(instr_valid), .load_data(load_data),
      .load_valid(load_valid), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] rd, input int sz, input bit sg);
      int w;
      int sh;
      logic [63:0] v;
      w = sz == 0 ? 8 : sz == 1 ? 16 : 32;
      sh = sz == 0 ? 8 * int'(a % 4) : sz == 1 ? 16 * int'((a / 2) % 2) : 0;
      if (w == 32) return rd;
      v = (64'(rd) >> sh) % (64'd1 << w);
      if (sg && v >= (64'd1 << (w - 1))) v = v - (64'd1 << w);
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input int sz);
      return sz == 0 ? 4'(1 << (a % 4)) : sz == 1 ? (((a / 2) % 2) != 0 ? 4'd12 : 4'd3) : 4'd15;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] sd, input int sz);
      return sz == 0 ? (sd % 256) * 32'h01010101 : sz == 1 ? (sd % 65536) * 32'h00010001 : sd;
   endfunction

   function automatic bit model_trap(input logic [31:0] a, input int sz);
`ifdef MEM_MISALIGN_TRAP_EN
      return sz == 1 ? (a % 2 != 0) : sz >= 2 ? (a % 4 != 0) : 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic txn(input bit is_fetch, input bit also_fetch, input bit src, input logic [31:0] pc_v,
                      input logic [31:0] alu_v, input logic [31:0] sd, input bit we, input logic [1:0] sz,
                      input bit sg, input int delay, input logic [31:0] rd);
      logic [31:0] a;
      int esz;
      bit is_load;
      a = (is_fetch || !src) ? pc_v : alu_v;
      esz = is_fetch ? 2 : int'(sz);
      is_load = !is_fetch && !we;
      fetch_req = is_fetch | also_fetch; mem_req = !is_fetch;
      addr_src = src; pc = pc_v; alu_result = alu_v; store_data = sd;
      mem_we = we; mem_size = sz; mem_signed = sg;
      @(negedge clk);
      fetch_req = 0; mem_req = 0;
      pc = $urandom; alu_result = $urandom; store_data = $urandom;
      mem_we = 1'($urandom); mem_size = 2'($urandom); mem_signed = 1'($urandom);
      if (model_trap(a, esz)) begin
         check("trap_fault", fault, 1);
         check("trap_ram_req", ram_req, 0);
         check("trap_valid", instr_valid | load_valid, 0);
         @(negedge clk);
         check("trap_fault_clr", fault, 0);
         check("trap_busy", busy, 0);
         return;
      end
      for (int i = 0; i <= delay; i++) begin
         check("ram_req", ram_req, 1);
         check("ram_addr", 32'(ram_addr), a >> 2);
         check("ram_be", 32'(ram_be), 32'(is_fetch ? 4'd15 : model_be(a, esz)));
         check("ram_we", ram_we, !is_fetch && we);
         if (!is_fetch && we) check("ram_wdata", ram_wdata, model_wdata(sd, esz));
         check("busy_req", busy, 1);
         check("valid_in_req", instr_valid | load_valid | fault, 0);
         ram_ack = (i == delay);
         ram_rdata = (i == delay) ? rd : $urandom;
         fetch_req = 1'($urandom); mem_req = 1'($urandom);
         @(negedge clk);
         fetch_req = 0; mem_req = 0; ram_ack = 0;
      end
      if (is_fetch) exp_instr = rd;
      if (is_load) exp_load = model_load(a, rd, esz, sg);
      check("instr_valid", instr_valid, is_fetch);
      check("load_valid", load_valid, is_load);
      check("instr", instr, exp_instr);
      check("load_data", load_data, exp_load);
      check("busy_done", busy, 1);
      check("ram_req_done", ram_req, 0);
      fetch_req = 1'($urandom); mem_req = 1'($urandom);
      @(negedge clk);
      fetch_req = 0; mem_req = 0;
      check("busy_idle", busy, 0);
      check("valid_idle", instr_valid | load_valid, 0);
      check("ram_req_idle", ram_req, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ram_req", ram_req, 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_ram_be", 32'(ram_be), 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_instr", instr, 0);
      check("rst_load", load_data, 0);
      check("rst_flags", {instr_valid, load_valid, busy, fault}, 0);
      reset = 0;
      txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 2'b10, 0, 0, 32'hCAFEF00D);
      check("fetch_instr", instr, 32'hCAFEF00D);
      txn(0, 0, 1, 32'h0, 32'h103, 32'h0, 0, 2'b00, 1, 0, 32'h80FFFFFF);
      check("lb_signed", load_data, 32'hFFFFFF80);
      txn(0, 0, 1, 32'h0, 32'h103, 32'h0, 0, 2'b00, 0, 1, 32'h80FFFFFF);
      check("lb_unsigned", load_data, 32'h00000080);
      txn(0, 0, 1, 32'h0, 32'h22, 32'h0000BEEF, 1, 2'b01, 0, 0, 32'h12345678);
      check("store_keeps_load", load_data, 32'h00000080);
      txn(1, 0, 0, 32'h200, 32'h0, 32'h0, 0, 2'b10, 0, 3, 32'h13579BDF);
      txn(0, 1, 0, 32'h84, 32'h0, 32'h0, 0, 2'b10, 0, 0, 32'h2468ACE0);
      check("both_no_fetch", instr, 32'h13579BDF);
      txn(0, 0, 1, 32'h0, 32'h102, 32'h0, 0, 2'b10, 0, 0, 32'hA5A5A5A5);
      // reset while a fetch is waiting for ack
      fetch_req = 1; pc = 32'h44;
      @(negedge clk);
      fetch_req = 0;
      check("rst_mid_req", ram_req, 1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      exp_instr = 0; exp_load = 0;
      check("rst_mid_ram_req", ram_req, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", instr_valid, 0);
      ram_ack = 1; ram_rdata = 32'hDEADBEEF;
      @(negedge clk);
      ram_ack = 0;
      check("late_ack_valid", instr_valid | load_valid, 0);
      check("late_ack_busy", busy, 0);
      check("late_ack_instr", instr, 0);
      for (int k = 0; k < 300; k++)
         txn($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
